// File: rtl/mask_row_loader_pkg.sv
// Constants and state encoding shared by the mask row loader and the exposure FSM.
package mask_row_loader_pkg;

    localparam int C_MASK_DES_L = 16;
    localparam int C_NUM_ROWS   = 176;
    localparam int C_ROW_CNT_W  = 8;
    localparam int C_PAT_CNT_W  = 32;

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_LOAD = 3'b010,
        S_DONE = 3'b100
    } state_t;

endpackage

// File: rtl/mask_row_loader.sv
// Pops one row mask word per CLKMPRE cycle while STREAM is high and drives the sensor mask pads;
// counts rows and bursts and raises sticky underrun / burst-length flags.
module mask_row_loader #(
    parameter int C_MASK_DES_L = mask_row_loader_pkg::C_MASK_DES_L,
    parameter int C_NUM_ROWS   = mask_row_loader_pkg::C_NUM_ROWS,
    parameter int C_ROW_CNT_W  = mask_row_loader_pkg::C_ROW_CNT_W
) (
    input  logic                                      CLKMPRE,
    input  logic                                      RESET_B,
    input  logic                                      STREAM,
    input  logic [C_MASK_DES_L-1:0]                   FIFO_DATA,
    input  logic                                      FIFO_VALID,
    output logic                                      FIFO_RD,
    output logic [C_MASK_DES_L-1:0]                   MASK_DATA,
    output logic                                      MASK_VALID,
    output logic [C_ROW_CNT_W-1:0]                    ROW_CNT,
    output logic [mask_row_loader_pkg::C_PAT_CNT_W-1:0] PAT_CNT,
    output logic                                      PAT_DONE,
    output logic                                      UNDERRUN,
    output logic                                      LEN_ERR,
    input  logic                                      CLR
);
    import mask_row_loader_pkg::*;

    localparam logic [C_ROW_CNT_W-1:0] ROWS = C_ROW_CNT_W'(C_NUM_ROWS);

    state_t                     state, state_nxt;
    logic [C_ROW_CNT_W-1:0]     row_base, row_nxt;
    logic [C_MASK_DES_L-1:0]    mask_nxt;
    logic [C_PAT_CNT_W-1:0]     pat_nxt;
    logic                       valid_nxt, done_nxt, und_nxt, len_nxt;
    logic                       do_load, rd;

    always_comb begin
        state_nxt = state;
        do_load   = 1'b0;
        rd        = 1'b0;
        row_base  = '0;
        row_nxt   = ROW_CNT;
        mask_nxt  = '0;
        valid_nxt = 1'b0;
        done_nxt  = 1'b0;
        pat_nxt   = CLR ? '0 : PAT_CNT;
        und_nxt   = UNDERRUN & ~CLR;
        len_nxt   = LEN_ERR & ~CLR;

        case (state)
            S_IDLE: begin
                if (STREAM) begin
                    do_load   = 1'b1;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                row_base = ROW_CNT;
                if (STREAM) begin
                    do_load = 1'b1;
                end else begin
                    if (ROW_CNT != ROWS) len_nxt = 1'b1;
                    pat_nxt   = pat_nxt + C_PAT_CNT_W'(1);
                    done_nxt  = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                row_nxt = '0;
                if (STREAM) begin
                    do_load   = 1'b1;
                    state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                row_nxt   = '0;
            end
        endcase

        // An empty FIFO still consumes the row slot so later rows keep their alignment.
        if (do_load) begin
            if (row_base < ROWS) begin
                row_nxt = row_base + C_ROW_CNT_W'(1);
                if (FIFO_VALID) begin
                    rd        = 1'b1;
                    mask_nxt  = FIFO_DATA;
                    valid_nxt = 1'b1;
                end else begin
                    und_nxt = 1'b1;
                end
            end else begin
                row_nxt = row_base;
                len_nxt = 1'b1;
            end
        end

        FIFO_RD = rd & RESET_B;
    end

    always_ff @(posedge CLKMPRE or negedge RESET_B) begin
        if (!RESET_B) begin
            state      <= S_IDLE;
            MASK_DATA  <= '0;
            MASK_VALID <= 1'b0;
            ROW_CNT    <= '0;
            PAT_CNT    <= '0;
            PAT_DONE   <= 1'b0;
            UNDERRUN   <= 1'b0;
            LEN_ERR    <= 1'b0;
        end else begin
            state      <= state_nxt;
            MASK_DATA  <= mask_nxt;
            MASK_VALID <= valid_nxt;
            ROW_CNT    <= row_nxt;
            PAT_CNT    <= pat_nxt;
            PAT_DONE   <= done_nxt;
            UNDERRUN   <= und_nxt;
            LEN_ERR    <= len_nxt;
        end
    end

endmodule

// File: tb/tb_mask_row_loader.sv
// Directed bench for mask_row_loader: a run-length model predicts every output cycle by cycle,
// backed by hand-computed checks at burst boundaries.
module tb_mask_row_loader;

    localparam int ROWS = 176;

    logic        clk = 1'b0;
    logic        RESET_B = 1'b0;
    logic        STREAM = 1'b0;
    logic        CLR = 1'b0;
    logic [15:0] FIFO_DATA = '0;
    logic        FIFO_VALID = 1'b0;
    logic        FIFO_RD;
    logic [15:0] MASK_DATA;
    logic        MASK_VALID;
    logic [7:0]  ROW_CNT;
    logic [31:0] PAT_CNT;
    logic        PAT_DONE;
    logic        UNDERRUN;
    logic        LEN_ERR;

    always #5 clk = ~clk;

    mask_row_loader #(
        .C_MASK_DES_L(16),
        .C_NUM_ROWS  (ROWS),
        .C_ROW_CNT_W (8)
    ) dut (
        .CLKMPRE   (clk),
        .RESET_B   (RESET_B),
        .STREAM    (STREAM),
        .FIFO_DATA (FIFO_DATA),
        .FIFO_VALID(FIFO_VALID),
        .FIFO_RD   (FIFO_RD),
        .MASK_DATA (MASK_DATA),
        .MASK_VALID(MASK_VALID),
        .ROW_CNT   (ROW_CNT),
        .PAT_CNT   (PAT_CNT),
        .PAT_DONE  (PAT_DONE),
        .UNDERRUN  (UNDERRUN),
        .LEN_ERR   (LEN_ERR),
        .CLR       (CLR)
    );

    int checks = 0;
    int failures = 0;
    int pops = 0;
    int dones = 0;

    logic [15:0] fifo_q[$];

    // Model: the row index of a cycle is simply how many STREAM-high cycles preceded it in this run.
    logic        m_prev = 1'b0;
    int          m_run = 0;
    logic [31:0] m_pat = '0;
    logic        m_und = 1'b0;
    logic        m_len = 1'b0;
    logic [15:0] exp_mask = '0;
    logic        exp_valid = 1'b0;
    int          exp_row = 0;
    logic        exp_done = 1'b0;
    logic        exp_rd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_zero();
        m_prev = 1'b0; m_run = 0; m_pat = '0; m_und = 1'b0; m_len = 1'b0;
        exp_mask = '0; exp_valid = 1'b0; exp_row = 0; exp_done = 1'b0;
    endtask

    function automatic logic model_rd();
        int r;
        r = m_prev ? m_run : 0;
        return RESET_B && STREAM && (r < ROWS) && (fifo_q.size() > 0);
    endfunction

    task automatic model_step();
        int r;
        if (!RESET_B) begin
            model_zero();
            return;
        end
        r = m_prev ? m_run : 0;
        if (CLR) begin
            m_pat = '0; m_und = 1'b0; m_len = 1'b0;
        end
        exp_done = 1'b0; exp_mask = '0; exp_valid = 1'b0;
        if (STREAM) begin
            m_run = r + 1;
            if (r < ROWS) begin
                exp_row = r + 1;
                if (fifo_q.size() > 0) begin
                    exp_mask  = fifo_q.pop_front();
                    exp_valid = 1'b1;
                end else begin
                    m_und = 1'b1;
                end
            end else begin
                exp_row = ROWS;
                m_len   = 1'b1;
            end
        end else if (m_prev) begin
            exp_done = 1'b1;
            m_pat    = m_pat + 32'd1;
            if (m_run != ROWS) m_len = 1'b1;
            exp_row = (m_run < ROWS) ? m_run : ROWS;
        end else begin
            exp_row = 0;
        end
        m_prev = STREAM;
    endtask

    task automatic present_fifo();
        FIFO_VALID = (fifo_q.size() > 0);
        FIFO_DATA  = (fifo_q.size() > 0) ? fifo_q[0] : 16'h0000;
    endtask

    task automatic drive(input logic s, input logic c);
        STREAM = s;
        CLR    = c;
        present_fifo();
        exp_rd = model_rd();
        @(negedge clk);
        #1;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_fifo(input int n, input int base);
        for (int i = 0; i < n; i++) fifo_q.push_back(16'(base + i));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            check("mask_data", 32'(MASK_DATA), 32'(exp_mask));
            check("mask_valid", 32'(MASK_VALID), 32'(exp_valid));
            check("row_cnt", 32'(ROW_CNT), 32'(exp_row));
            check("pat_cnt", PAT_CNT, m_pat);
            check("pat_done", 32'(PAT_DONE), 32'(exp_done));
            check("underrun", 32'(UNDERRUN), 32'(m_und));
            check("len_err", 32'(LEN_ERR), 32'(m_len));
            check("fifo_rd", 32'(FIFO_RD), 32'(exp_rd));
            check("rd_when_empty", 32'(FIFO_RD & ~FIFO_VALID), 32'd0);
            if (FIFO_RD) pops++;
            if (PAT_DONE) dones++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, d0;

        // Reset
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("rst_pat_cnt", PAT_CNT, 32'd0);
        check("rst_row_cnt", 32'(ROW_CNT), 32'd0);
        check("rst_fifo_rd", 32'(FIFO_RD), 32'd0);
        RESET_B = 1'b1;

        // Full burst
        load_fifo(ROWS, 1);
        p0 = pops; d0 = dones;
        for (int i = 0; i < ROWS; i++) begin
            drive(1'b1, 1'b0);
            if (i == 0) begin
                check("t1_first_word", 32'(MASK_DATA), 32'h0001);
                check("t1_first_row", 32'(ROW_CNT), 32'd1);
            end
        end
        check("t1_last_word", 32'(MASK_DATA), 32'h00B0);
        drive(1'b0, 1'b0);
        check("t1_row_cnt", 32'(ROW_CNT), 32'd176);
        check("t1_pat_cnt", PAT_CNT, 32'd1);
        check("t1_pat_done", 32'(PAT_DONE), 32'd1);
        drive(1'b0, 1'b0);
        check("t1_pops", 32'(pops - p0), 32'd176);
        check("t1_dones", 32'(dones - d0), 32'd1);
        check("t1_underrun", 32'(UNDERRUN), 32'd0);
        check("t1_len_err", 32'(LEN_ERR), 32'd0);

        // Underrun burst, CLR coinciding with the first empty row
        load_fifo(100, 16'h1000);
        p0 = pops;
        for (int i = 0; i < ROWS; i++) begin
            drive(1'b1, logic'(i == 100));
            if (i == 100) check("t2_clr_vs_set", 32'(UNDERRUN), 32'd1);
            if (i == 150) check("t2_empty_valid", 32'(MASK_VALID), 32'd0);
        end
        drive(1'b0, 1'b0);
        check("t2_row_cnt", 32'(ROW_CNT), 32'd176);
        check("t2_pat_cnt", PAT_CNT, 32'd1);
        drive(1'b0, 1'b0);
        check("t2_pops", 32'(pops - p0), 32'd100);
        check("t2_underrun", 32'(UNDERRUN), 32'd1);
        check("t2_len_err", 32'(LEN_ERR), 32'd0);

        // CLR alone
        drive(1'b0, 1'b1);
        check("clr_underrun", 32'(UNDERRUN), 32'd0);
        check("clr_len_err", 32'(LEN_ERR), 32'd0);
        check("clr_pat_cnt", PAT_CNT, 32'd0);

        // Over-long burst
        load_fifo(200, 16'h3000);
        p0 = pops;
        for (int i = 0; i < 180; i++) drive(1'b1, 1'b0);
        check("t3_row_sat", 32'(ROW_CNT), 32'd176);
        drive(1'b0, 1'b0);
        check("t3_len_err", 32'(LEN_ERR), 32'd1);
        check("t3_pops", 32'(pops - p0), 32'd176);
        check("t3_pat_cnt", PAT_CNT, 32'd1);
        fifo_q.delete();
        drive(1'b0, 1'b1);

        // Short burst
        load_fifo(200, 16'h4000);
        p0 = pops;
        for (int i = 0; i < 170; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("t3b_row_cnt", 32'(ROW_CNT), 32'd170);
        check("t3b_len_err", 32'(LEN_ERR), 32'd1);
        check("t3b_pat_cnt", PAT_CNT, 32'd1);
        check("t3b_pops", 32'(pops - p0), 32'd170);
        fifo_q.delete();
        drive(1'b0, 1'b1);

        // Back-to-back bursts through a single low cycle
        load_fifo(2 * ROWS, 1);
        p0 = pops; d0 = dones;
        for (int i = 0; i < ROWS; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        for (int i = 0; i < ROWS; i++) begin
            drive(1'b1, 1'b0);
            if (i == 0) check("t4_second_first", 32'(MASK_DATA), 32'h00B1);
        end
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        check("t4_pat_cnt", PAT_CNT, 32'd2);
        check("t4_dones", 32'(dones - d0), 32'd2);
        check("t4_pops", 32'(pops - p0), 32'd352);
        check("t4_len_err", 32'(LEN_ERR), 32'd0);

        // Asynchronous reset mid-burst
        load_fifo(200, 16'h2000);
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b0);
        check("t5_row_50", 32'(ROW_CNT), 32'd50);
        RESET_B = 1'b0;
        #1;
        check("t5_async_row", 32'(ROW_CNT), 32'd0);
        check("t5_async_valid", 32'(MASK_VALID), 32'd0);
        check("t5_async_data", 32'(MASK_DATA), 32'd0);
        check("t5_async_pat", PAT_CNT, 32'd0);
        model_zero();
        drive(1'b1, 1'b0);
        RESET_B = 1'b1;
        for (int i = 0; i < 126; i++) drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
        check("t5_row_cnt", 32'(ROW_CNT), 32'd126);
        check("t5_len_err", 32'(LEN_ERR), 32'd1);
        check("t5_pat_cnt", PAT_CNT, 32'd1);
        drive(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
